// File: rtl/shift_seq.sv
// shift_seq: command sequencer for a WIDTH-bit bidirectional shift register
// with enable and synchronous clear.
//
// Accepts one command at a time over cmd_valid/cmd_ready. The operations are
// CLEAR, serial LOAD (MSB first), SHIFT and ROTATE. The sequencer drives the
// register's sr_clr/sr_en/sr_shf/sr_d pins for the required number of cycles.
// It then returns the final register contents on res with a one-cycle done
// pulse.
//
// Optional feature macro: SHIFT_SEQ_ABORT_EN
//   Adds input abort and output aborted. abort in CLR or RUN ends the command
//   early. done still pulses, and aborted is high with it.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   clr        in   asynchronous active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  sequencer can accept a command
//   cmd_op     in   0 CLEAR, 1 LOAD, 2 SHIFT, 3 ROTATE
//   cmd_dir    in   0 left, 1 right (SHIFT/ROTATE)
//   cmd_fill   in   bit shifted in (SHIFT)
//   cmd_amt    in   number of positions (SHIFT/ROTATE), executed literally
//   cmd_data   in   word to load (LOAD)
//   sr_clr     out  synchronous clear to the register
//   sr_en      out  register shift enable
//   sr_shf     out  direction: 0 left q<={q[W-2:0],d}, 1 right q<={d,q[W-1:1]}
//   sr_d       out  register serial input
//   sr_q       in   register contents
//   busy       out  a command is in progress (CLR, RUN, DONE)
//   done       out  one-cycle completion pulse
//   res        out  sr_q captured at completion, held until the next done
//   abort      in   (SHIFT_SEQ_ABORT_EN) end current CLR/RUN early
//   aborted    out  (SHIFT_SEQ_ABORT_EN) high with the done of an aborted command
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a command, cmd_ready=1 (except in the done cycle)
// CLR    | sr_clr high for this one cycle
// RUN    | sr_en high, cnt counts down the remaining shift cycles
// DONE   | register has settled after the last edge; capture res, pulse done

module shift_seq #(
   parameter int WIDTH = 4,
   parameter int AW    = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic             cmd_dir,
   input  logic             cmd_fill,
   input  logic [AW-1:0]    cmd_amt,
   input  logic [WIDTH-1:0] cmd_data,
   output logic             sr_clr,
   output logic             sr_en,
   output logic             sr_shf,
   output logic             sr_d,
   input  logic [WIDTH-1:0] sr_q,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res
`ifdef SHIFT_SEQ_ABORT_EN
   ,
   input  logic             abort,
   output logic             aborted
`endif
);

   localparam logic [1:0] OP_CLEAR  = 2'd0;
   localparam logic [1:0] OP_LOAD   = 2'd1;
   localparam logic [1:0] OP_SHIFT  = 2'd2;
   localparam logic [1:0] OP_ROTATE = 2'd3;

   localparam logic [AW-1:0] LOAD_CNT = AW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLR,
      S_RUN,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [AW-1:0]    cnt, cnt_nxt;
   logic [1:0]       op_q, op_nxt;
   logic             dir_q, dir_nxt;
   logic             fill_q, fill_nxt;
   logic [WIDTH-1:0] dat_q, dat_nxt;

   logic             sr_clr_nxt, sr_en_nxt, sr_shf_nxt, sr_d_nxt;
   logic             busy_nxt, done_nxt;
   logic [WIDTH-1:0] res_nxt;
   logic             accept;

`ifdef SHIFT_SEQ_ABORT_EN
   logic             abt_flag, abt_flag_nxt;
   logic             aborted_nxt;
`endif

   // Held low during the done cycle so a held cmd_valid is only taken the
   // cycle after done.
   assign cmd_ready = (state == S_IDLE) && !done;
   assign accept    = cmd_valid && cmd_ready;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state  <= S_IDLE;
         cnt    <= '0;
         op_q   <= '0;
         dir_q  <= 1'b0;
         fill_q <= 1'b0;
         dat_q  <= '0;
         sr_clr <= 1'b0;
         sr_en  <= 1'b0;
         sr_shf <= 1'b0;
         sr_d   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         res    <= '0;
`ifdef SHIFT_SEQ_ABORT_EN
         abt_flag <= 1'b0;
         aborted  <= 1'b0;
`endif
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         op_q   <= op_nxt;
         dir_q  <= dir_nxt;
         fill_q <= fill_nxt;
         dat_q  <= dat_nxt;
         sr_clr <= sr_clr_nxt;
         sr_en  <= sr_en_nxt;
         sr_shf <= sr_shf_nxt;
         sr_d   <= sr_d_nxt;
         busy   <= busy_nxt;
         done   <= done_nxt;
         res    <= res_nxt;
`ifdef SHIFT_SEQ_ABORT_EN
         abt_flag <= abt_flag_nxt;
         aborted  <= aborted_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      op_nxt     = op_q;
      dir_nxt    = dir_q;
      fill_nxt   = fill_q;
      dat_nxt    = dat_q;
      sr_clr_nxt = 1'b0;
      sr_en_nxt  = 1'b0;
      sr_shf_nxt = sr_shf;
      sr_d_nxt   = sr_d;
      done_nxt   = 1'b0;
      res_nxt    = res;
`ifdef SHIFT_SEQ_ABORT_EN
      abt_flag_nxt = abt_flag;
      aborted_nxt  = 1'b0;
`endif

      case (state)
         S_IDLE: begin
            if (accept) begin
               op_nxt   = cmd_op;
               dir_nxt  = cmd_dir;
               fill_nxt = cmd_fill;
               dat_nxt  = cmd_data;
`ifdef SHIFT_SEQ_ABORT_EN
               abt_flag_nxt = 1'b0;
`endif
               case (cmd_op)
                  OP_CLEAR: begin
                     state_nxt  = S_CLR;
                     sr_clr_nxt = 1'b1;
                  end
                  OP_LOAD: begin
                     state_nxt  = S_RUN;
                     cnt_nxt    = LOAD_CNT;
                     sr_en_nxt  = 1'b1;
                     sr_shf_nxt = 1'b0;
                     sr_d_nxt   = cmd_data[WIDTH-1];
                     dat_nxt    = cmd_data << 1;
                  end
                  default: begin
                     if (cmd_amt == '0) begin
                        state_nxt = S_DONE;
                     end else begin
                        state_nxt  = S_RUN;
                        cnt_nxt    = cmd_amt - 1'b1;
                        sr_en_nxt  = 1'b1;
                        sr_shf_nxt = cmd_dir;
                        if (cmd_op == OP_SHIFT)
                           sr_d_nxt = cmd_fill;
                        else
                           sr_d_nxt = cmd_dir ? sr_q[0] : sr_q[WIDTH-1];
                     end
                  end
               endcase
            end
         end

         S_CLR: begin
            state_nxt = S_DONE;
`ifdef SHIFT_SEQ_ABORT_EN
            if (abort)
               abt_flag_nxt = 1'b1;
`endif
         end

         S_RUN: begin
`ifdef SHIFT_SEQ_ABORT_EN
            if (abort) begin
               state_nxt    = S_DONE;
               abt_flag_nxt = 1'b1;
            end else
`endif
            if (cnt == '0) begin
               state_nxt = S_DONE;
            end else begin
               cnt_nxt   = cnt - 1'b1;
               sr_en_nxt = 1'b1;
               case (op_q)
                  OP_LOAD: begin
                     sr_d_nxt = dat_q[WIDTH-1];
                     dat_nxt  = dat_q << 1;
                  end
                  OP_SHIFT: sr_d_nxt = fill_q;
                  // The register shifts on this same edge, so the feedback bit
                  // for the next cycle is the one that becomes the end bit.
                  OP_ROTATE: sr_d_nxt = dir_q ? sr_q[1] : sr_q[WIDTH-2];
                  default: sr_d_nxt = sr_d;
               endcase
            end
         end

         S_DONE: begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
            res_nxt   = sr_q;
`ifdef SHIFT_SEQ_ABORT_EN
            aborted_nxt = abt_flag;
`endif
         end

         default: state_nxt = S_IDLE;
      endcase

      busy_nxt = (state_nxt != S_IDLE);
   end

endmodule

// File: tb/tb_shift_seq.sv
module tb_shift_seq;

   logic       tb_clk = 1'b0;
   logic       clr;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic       cmd_dir;
   logic       cmd_fill;
   logic [2:0] cmd_amt;
   logic [3:0] cmd_data;
   logic       sr_clr, sr_en, sr_shf, sr_d;
   logic [3:0] sr_q;
   logic       busy, done;
   logic [3:0] res;
`ifdef SHIFT_SEQ_ABORT_EN
   logic       abort;
   logic       aborted;
`endif

   int checks   = 0;
   int failures = 0;

   // Behavioural enabled shift register on the sr_* pins; not reset by clr.
   logic [3:0] q_model;
   logic       pre_en;
   logic [3:0] pre_val;

   assign sr_q = q_model;

   always #5 tb_clk = ~tb_clk;

   always @(posedge tb_clk) begin
      if (pre_en)
         q_model <= pre_val;
      else if (sr_clr)
         q_model <= 4'b0000;
      else if (sr_en)
         q_model <= sr_shf ? {sr_d, q_model[3:1]} : {q_model[2:0], sr_d};
   end

   shift_seq #(.WIDTH(4)) dut (
      .clk       (tb_clk),
      .clr       (clr),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_dir   (cmd_dir),
      .cmd_fill  (cmd_fill),
      .cmd_amt   (cmd_amt),
      .cmd_data  (cmd_data),
      .sr_clr    (sr_clr),
      .sr_en     (sr_en),
      .sr_shf    (sr_shf),
      .sr_d      (sr_d),
      .sr_q      (sr_q),
      .busy      (busy),
      .done      (done),
      .res       (res)
`ifdef SHIFT_SEQ_ABORT_EN
      ,
      .abort     (abort),
      .aborted   (aborted)
`endif
   );

   // Observations from the most recent issue() call.
   int         o_lat;
   int         o_en;
   int         o_clr;
   logic [3:0] o_dseq;
   logic       o_shf_or, o_shf_and;
   logic       o_rdy_bad, o_busy_bad, o_rdy_start;
   logic [3:0] o_res;
   logic       o_ab;

   task automatic tick();
      @(posedge tb_clk);
      #1;
   endtask

   task automatic preload(input logic [3:0] v);
      pre_val = v;
      pre_en  = 1'b1;
      tick();
      pre_en  = 1'b0;
   endtask

   // Presents one command, then watches every cycle until done (bounded).
   task automatic issue(input logic [1:0] op, input logic dir, input logic fill,
                        input logic [2:0] amt, input logic [3:0] data, input bit hold);
      o_rdy_start = cmd_ready;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_dir   = dir;
      cmd_fill  = fill;
      cmd_amt   = amt;
      cmd_data  = data;
      tick();
      if (!hold) cmd_valid = 1'b0;
      o_lat = -1; o_en = 0; o_clr = 0; o_dseq = 4'b0000;
      o_shf_or = 1'b0; o_shf_and = 1'b1; o_rdy_bad = 1'b0; o_busy_bad = 1'b0;
      o_res = 4'bxxxx; o_ab = 1'b0;
      for (int j = 0; j < 30; j++) begin
         if (cmd_ready) o_rdy_bad = 1'b1;
         if (sr_en) begin
            o_en++;
            o_dseq    = {o_dseq[2:0], sr_d};
            o_shf_or  = o_shf_or | sr_shf;
            o_shf_and = o_shf_and & sr_shf;
         end
         if (sr_clr) o_clr++;
         if (done) begin
            if (busy) o_busy_bad = 1'b1;
            o_lat = j;
            o_res = res;
`ifdef SHIFT_SEQ_ABORT_EN
            o_ab = aborted;
`endif
            break;
         end
         if (!busy) o_busy_bad = 1'b1;
         tick();
      end
   endtask

   task automatic test_reset();
      clr = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_dir = 1'b0; cmd_fill = 1'b0;
      cmd_amt = 3'd0; cmd_data = 4'd0; pre_en = 1'b0; pre_val = 4'd0;
`ifdef SHIFT_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      #2;
      preload(4'b1111);
      tick();
      checks++;
      if ({cmd_ready, busy, done, sr_clr, sr_en, sr_shf, sr_d} !== 7'b1000000) begin
         failures++;
         $display("FAIL reset_ctrl got %b want 1000000",
                  {cmd_ready, busy, done, sr_clr, sr_en, sr_shf, sr_d});
      end
      checks++;
      if (res !== 4'b0000) begin failures++; $display("FAIL reset_res got %b want 0000", res); end
      clr = 1'b1;
      tick();
   endtask

   task automatic test_clear();
      issue(2'd0, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0);
      checks++; if (o_rdy_start !== 1'b1) begin failures++; $display("FAIL clear_ready_start got %b want 1", o_rdy_start); end
      checks++; if (o_clr != 1) begin failures++; $display("FAIL clear_clr_cycles got %0d want 1", o_clr); end
      checks++; if (o_en != 0) begin failures++; $display("FAIL clear_en_cycles got %0d want 0", o_en); end
      checks++; if (o_lat != 2) begin failures++; $display("FAIL clear_latency got %0d want 2", o_lat); end
      checks++; if (o_res !== 4'b0000) begin failures++; $display("FAIL clear_res got %b want 0000", o_res); end
      checks++; if (o_busy_bad || o_rdy_bad) begin failures++; $display("FAIL clear_handshake busy_bad=%b rdy_bad=%b want 0 0", o_busy_bad, o_rdy_bad); end
      tick();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL clear_done_width got %b want 0", done); end
   endtask

   task automatic test_load();
      issue(2'd1, 1'b1, 1'b1, 3'd5, 4'b1011, 1'b0);
      checks++; if (o_en != 4) begin failures++; $display("FAIL load_en_cycles got %0d want 4", o_en); end
      checks++; if (o_dseq !== 4'b1011) begin failures++; $display("FAIL load_d_seq got %b want 1011", o_dseq); end
      checks++; if (o_shf_or !== 1'b0) begin failures++; $display("FAIL load_shf got %b want 0", o_shf_or); end
      checks++; if (o_lat != 5) begin failures++; $display("FAIL load_latency got %0d want 5", o_lat); end
      checks++; if (o_res !== 4'b1011) begin failures++; $display("FAIL load_res got %b want 1011", o_res); end
      checks++; if (o_busy_bad || o_rdy_bad) begin failures++; $display("FAIL load_handshake busy_bad=%b rdy_bad=%b want 0 0", o_busy_bad, o_rdy_bad); end
`ifdef SHIFT_SEQ_ABORT_EN
      checks++; if (o_ab !== 1'b0) begin failures++; $display("FAIL load_aborted got %b want 0", o_ab); end
`endif
      tick();
   endtask

   task automatic test_shift();
      issue(2'd2, 1'b0, 1'b0, 3'd2, 4'b1111, 1'b0);
      checks++; if (o_res !== 4'b1100) begin failures++; $display("FAIL shl2_res got %b want 1100", o_res); end
      checks++; if (o_lat != 3 || o_en != 2) begin failures++; $display("FAIL shl2_timing lat=%0d en=%0d want 3 2", o_lat, o_en); end
      checks++; if (o_rdy_bad) begin failures++; $display("FAIL shl2_ready got high want low"); end
      tick();
      issue(2'd2, 1'b1, 1'b1, 3'd1, 4'b0000, 1'b0);
      checks++; if (o_res !== 4'b1110) begin failures++; $display("FAIL shr1_res got %b want 1110", o_res); end
      checks++; if (o_lat != 2 || o_en != 1 || o_shf_and !== 1'b1) begin failures++; $display("FAIL shr1_timing lat=%0d en=%0d shf=%b want 2 1 1", o_lat, o_en, o_shf_and); end
      checks++; if (o_rdy_bad) begin failures++; $display("FAIL shr1_ready got high want low"); end
      tick();
   endtask

   task automatic test_rotate();
      issue(2'd3, 1'b0, 1'b0, 3'd1, 4'b0000, 1'b0);
      checks++; if (o_res !== 4'b1101) begin failures++; $display("FAIL rol1_res got %b want 1101", o_res); end
      checks++; if (o_dseq !== 4'b0001) begin failures++; $display("FAIL rol1_d_seq got %b want 0001", o_dseq); end
      tick();
      issue(2'd3, 1'b1, 1'b0, 3'd4, 4'b0000, 1'b0);
      checks++; if (o_res !== 4'b1101) begin failures++; $display("FAIL ror4_res got %b want 1101", o_res); end
      checks++; if (o_en != 4 || o_lat != 5) begin failures++; $display("FAIL ror4_timing en=%0d lat=%0d want 4 5", o_en, o_lat); end
      checks++; if (o_dseq !== 4'b1011) begin failures++; $display("FAIL ror4_d_seq got %b want 1011", o_dseq); end
      tick();
      // amt beyond WIDTH runs literally and leaves only fill bits.
      issue(2'd2, 1'b1, 1'b0, 3'd5, 4'b0000, 1'b0);
      checks++; if (o_res !== 4'b0000) begin failures++; $display("FAIL shr5_res got %b want 0000", o_res); end
      checks++; if (o_en != 5 || o_lat != 6) begin failures++; $display("FAIL shr5_timing en=%0d lat=%0d want 5 6", o_en, o_lat); end
      tick();
   endtask

   task automatic test_back_to_back();
      preload(4'b1001);
      issue(2'd2, 1'b0, 1'b1, 3'd0, 4'b0000, 1'b1);
      checks++; if (o_lat != 1) begin failures++; $display("FAIL amt0_latency got %0d want 1", o_lat); end
      checks++; if (o_en != 0) begin failures++; $display("FAIL amt0_en_cycles got %0d want 0", o_en); end
      checks++; if (o_res !== 4'b1001) begin failures++; $display("FAIL amt0_res got %b want 1001", o_res); end
      checks++; if (o_rdy_bad) begin failures++; $display("FAIL b2b_ready_in_done got high want low"); end
      tick();
      checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL b2b_ready_after got ready=%b busy=%b want 1 0", cmd_ready, busy); end
      issue(2'd3, 1'b0, 1'b0, 3'd2, 4'b0000, 1'b0);
      checks++; if (o_res !== 4'b0110 || o_lat != 3) begin failures++; $display("FAIL b2b_second got res=%b lat=%0d want 0110 3", o_res, o_lat); end
      tick();
   endtask

   task automatic test_reset_mid();
      logic seen_done;
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 4'b1111;
      tick();
      cmd_valid = 1'b0;
      tick();
      checks++; if (sr_en !== 1'b1) begin failures++; $display("FAIL rstmid_running got sr_en=%b want 1", sr_en); end
      clr = 1'b0;
      #1;
      checks++;
      if ({cmd_ready, busy, done, sr_clr, sr_en, sr_shf, sr_d} !== 7'b1000000 || res !== 4'b0000) begin
         failures++;
         $display("FAIL rstmid_outputs got ctrl=%b res=%b want 1000000 0000",
                  {cmd_ready, busy, done, sr_clr, sr_en, sr_shf, sr_d}, res);
      end
      seen_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done) seen_done = 1'b1;
      end
      clr = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done) seen_done = 1'b1;
      end
      checks++; if (seen_done) begin failures++; $display("FAIL rstmid_no_done got done=1 want 0"); end
   endtask

`ifdef SHIFT_SEQ_ABORT_EN
   task automatic test_abort();
      preload(4'b0000);
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 4'b1111;
      tick();
      cmd_valid = 1'b0;
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++; if (sr_en !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL abort_stop got sr_en=%b busy=%b want 0 1", sr_en, busy); end
      tick();
      checks++; if (done !== 1'b1 || aborted !== 1'b1) begin failures++; $display("FAIL abort_done got done=%b aborted=%b want 1 1", done, aborted); end
      checks++; if (res !== 4'b0011) begin failures++; $display("FAIL abort_res got %b want 0011", res); end
      tick();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_clear();
      test_load();
      test_shift();
      test_rotate();
      test_back_to_back();
      test_reset_mid();
`ifdef SHIFT_SEQ_ABORT_EN
      test_abort();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Command sequencer for the team's WIDTH-bit bidirectional shift register with enable.
- Accepts one command at a time over a valid/ready handshake: CLEAR, serial LOAD, SHIFT or ROTATE.
- Drives the register's clear, enable, direction and serial-data pins for the required number of cycles, then returns the final register contents with a one-cycle done pulse.
- Sits between the register and any bus or host FSM that needs multi-bit shift operations.

Parameters:
- WIDTH, 4, register width in bits (>=2).
- AW, $clog2(WIDTH)+1, width of cmd_amt.

Ports:
- clk  in  1  clock, all state on rising edge.
- clr  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  operation: 0 CLEAR, 1 LOAD, 2 SHIFT, 3 ROTATE.
- cmd_dir  in  1  direction: 0 left, 1 right. Ignored for CLEAR and LOAD.
- cmd_fill  in  1  bit shifted in, SHIFT only.
- cmd_amt  in  AW  number of positions, SHIFT and ROTATE only.
- cmd_data  in  WIDTH  word to load, LOAD only.
- sr_clr  out  1  synchronous clear to the register.
- sr_en  out  1  register shift enable.
- sr_shf  out  1  register direction: 0 left `q<={q[W-2:0],d}`, 1 right `q<={d,q[W-1:1]}`.
- sr_d  out  1  register serial input.
- sr_q  in  WIDTH  register contents.
- busy  out  1  a command is in progress.
- done  out  1  one-cycle completion pulse.
- res  out  WIDTH  sr_q captured at completion; held until the next done.

Behaviour:
- Reset (clr=0, asynchronous):
  - State goes to IDLE.
  - cmd_ready=1; busy, done, sr_clr, sr_en, sr_shf, sr_d all 0; res=0; counters 0.
  - The external register is not cleared by reset.
- All sr_* outputs, busy, done and res are registered.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch op, dir, fill, amt and data. Go to CLR for op 0, RUN for op 1-3. If op 2/3 and amt=0, go straight to DONE.
  - CLR: sr_clr=1 for exactly 1 cycle, sr_en=0, then DONE.
  - RUN: sr_en=1 for exactly N cycles, then DONE.
    - LOAD: N=WIDTH, sr_shf=0, sr_d = data[WIDTH-1-k] in the k-th cycle (MSB first).
    - SHIFT: N=amt, sr_shf=dir, sr_d=fill.
    - ROTATE: N=amt, sr_shf=dir, sr_d = sr_q[WIDTH-1] for left, sr_q[0] for right (live feedback each cycle).
  - DONE: done=1 for 1 cycle, res<=sr_q (post-final-edge value), then IDLE.
- Timing and handshake:
  - cmd_ready=0 and busy=1 in CLR, RUN and DONE.
  - Handshake-to-done latency is N+1 cycles for RUN ops, 2 cycles for CLEAR, 1 cycle for amt=0.
  - The next command can be accepted in the cycle after done.
  - Command inputs are don't-care while cmd_ready=0; latched copies are used throughout.
- Operands:
  - amt is executed literally, with no clamping.
  - SHIFT with amt>=WIDTH yields all fill bits.
  - ROTATE with amt=WIDTH returns the original value.
- Outside RUN and CLR, sr_en=0 and sr_clr=0; sr_d and sr_shf hold their last values.
- Reset mid-command aborts immediately with no done; register contents after that are undefined.

Optional Feature:
- Macro SHIFT_SEQ_ABORT_EN.
- When defined:
  - Adds input `abort` (1 bit).
  - abort=1 in CLR or RUN deasserts sr_en and sr_clr on the next edge and moves to DONE. done still pulses, with res = sr_q at that point.
  - Adds output `aborted` (1 bit), high together with that done pulse.
  - abort is ignored in IDLE and DONE.
- When undefined: neither port exists and commands always run to completion.

Test Plan:
- Bench setup: WIDTH=4; the bench includes a behavioural enabled shift-register model on the sr_* pins.
- Reset, then CLEAR on a register preloaded to 1111 -> sr_clr high for 1 cycle, done 2 cycles after handshake, res=0000.
- LOAD cmd_data=1011 -> sr_en high for 4 cycles, sr_d sequence 1,0,1,1, sr_shf=0, done on cycle 5, res=1011.
- From 1011: SHIFT dir=0 amt=2 fill=0 -> res=1100. Then SHIFT dir=1 amt=1 fill=1 -> res=1110. cmd_ready stays low throughout each command.
- From 1110: ROTATE dir=0 amt=1 -> res=1101. Then ROTATE dir=1 amt=4 -> res=1101 with 4 sr_en cycles.
- SHIFT amt=0 -> done 1 cycle after handshake, sr_en never asserted, res equals current register value. Back-to-back cmd_valid held high -> second command accepted the cycle after done.
- Assert clr=0 in the 2nd cycle of a LOAD -> all outputs take reset values immediately with no done. With SHIFT_SEQ_ABORT_EN defined, abort in the 2nd RUN cycle of LOAD 1111 from 0000 -> done and aborted high, res=0011.
